xor3_parity_rx: RTL and testbench

Serial receive-side parity checker, the counterpart of the team's `xor3` parity generator. It accepts a frame of `DATA_BITS` data bits (LSB first) followed by one parity bit on a 1-bit serial input with a valid qualifier. It reassembles the data word, recomputes the XOR parity and flags any mismatch. It sits after the serial link, at the end opposite the transmitter that appends `a^b^c`-style parity.

---
 rtl/xor3_parity_rx.sv | 138 +++++++++++++
 tb/tb_xor3_parity_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor3_parity_rx.sv
// xor3_parity_rx: serial receive-side parity checker.
// Collects DATA_BITS data bits (LSB first) plus one parity bit on a valid-
// qualified serial input, recomputes XOR parity and flags a mismatch.
//
// Handshake: there is no backpressure. A bit is consumed on every rising
// edge where sin_valid is 1; sin_start and sin_bit are ignored otherwise.
// data_valid and frame_err are single-cycle pulses, and data_out/parity_err
// hold until the next completed frame.
module xor3_parity_rx #(
  parameter int DATA_BITS = 3,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sin_valid,
  input  logic                 sin_start,
  input  logic                 sin_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  // With a single data bit the start bit is also the last data bit.
  localparam logic [1:0]    START_NEXT = (DATA_BITS == 1) ? S_PARITY : S_DATA;
  localparam logic [CW-1:0] LAST_POS   = CW'(DATA_BITS - 1);
  localparam logic          ODD_BIT    = (ODD != 0);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  // State register; reset drops any frame in progress without flagging it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a start bit always (re)opens a frame, from any state.
  always_comb begin
    state_d = state_q;
    if (sin_valid) begin
      if (sin_start) begin
        state_d = START_NEXT;
      end else begin
        case (state_q)
          S_DATA:   if (cnt_q == LAST_POS) state_d = S_PARITY;
          S_PARITY: state_d = S_IDLE;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  // Datapath and output next values; outputs are all registered below.
  always_comb begin
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        shreg_d     = '0;
        shreg_d[0]  = sin_bit;
        acc_d       = sin_bit;
        cnt_d       = CW'(1);
        frame_err_d = (state_q != S_IDLE);
      end else begin
        case (state_q)
          S_DATA: begin
            shreg_d[cnt_q] = sin_bit;
            acc_d          = acc_q ^ sin_bit;
            cnt_d          = cnt_q + CW'(1);
          end
          S_PARITY: begin
            data_out_d   = shreg_q;
            parity_err_d = acc_q ^ sin_bit ^ ODD_BIT;
            data_valid_d = 1'b1;
            cnt_d        = '0;
          end
          default: ;
        endcase
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      acc_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_xor3_parity_rx.sv
// Bench for xor3_parity_rx: directed frames from the test plan followed by
// random traffic, checked every cycle against a frame-level model. An even
// and an odd parity instance share the same serial input.
module tb_xor3_parity_rx;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin_start = 1'b0;
  logic         sin_bit = 1'b0;
  logic [W-1:0] data_out, data_out_o1;
  logic         data_valid, data_valid_o1;
  logic         parity_err, parity_err_o1;
  logic         frame_err, frame_err_o1;
  logic         busy, busy_o1;
  logic [1:0]   dbg_state, dbg_state_o1;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  xor3_parity_rx #(.DATA_BITS(W), .ODD(0)) dut (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_start(sin_start),
    .sin_bit(sin_bit), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  xor3_parity_rx #(.DATA_BITS(W), .ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_start(sin_start),
    .sin_bit(sin_bit), .data_out(data_out_o1), .data_valid(data_valid_o1),
    .parity_err(parity_err_o1), .frame_err(frame_err_o1), .busy(busy_o1),
    .dbg_state(dbg_state_o1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is simply the list of bits received since the last start bit.
  bit           model_bits[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data;
  logic         exp_dv, exp_fe, exp_busy, exp_perr, exp_perr_odd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_bits.delete();
      exp_q.delete();
      exp_data = '0; exp_dv = 0; exp_fe = 0; exp_busy = 0;
      exp_perr = 0; exp_perr_odd = 0;
    end else begin
      exp_dv = 0;
      exp_fe = 0;
      if (sin_valid) begin
        if (sin_start) begin
          exp_fe = (model_bits.size() != 0);
          model_bits.delete();
          model_bits.push_back(sin_bit);
        end else if (model_bits.size() != 0) begin
          model_bits.push_back(sin_bit);
        end
        if (model_bits.size() == W + 1) begin
          int ones;
          logic [W-1:0] word;
          ones = 0;
          word = '0;
          for (int i = 0; i < W; i++) begin
            word[i] = model_bits[i];
            ones += int'(model_bits[i]);
          end
          ones += int'(model_bits[W]);
          exp_perr     = (ones % 2) == 1;
          exp_perr_odd = (ones % 2) == 0;
          exp_data     = word;
          exp_dv       = 1;
          exp_q.push_back(word);
          model_bits.delete();
        end
      end
      exp_busy = (model_bits.size() != 0);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("data_valid", data_valid, exp_dv);
      check("frame_err", frame_err, exp_fe);
      check("busy", busy, exp_busy);
      check("data_out", data_out, exp_data);
      check("parity_err", parity_err, exp_perr);
      check("odd_data_valid", data_valid_o1, exp_dv);
      check("odd_frame_err", frame_err_o1, exp_fe);
      check("odd_busy", busy_o1, exp_busy);
      check("odd_data_out", data_out_o1, exp_data);
      check("odd_parity_err", parity_err_o1, exp_perr_odd);
      if (data_valid) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", data_out, 32'hdead);
        else check("sb_word", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic s, input logic b);
    @(negedge clk);
    sin_valid = 1'b1;
    sin_start = s;
    sin_bit   = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      sin_valid = 1'b0;
      sin_start = 1'($urandom_range(0, 1));
      sin_bit   = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // 1: good frame
    send(1, 1); send(0, 0); send(0, 1); send(0, 0);
    gap(1);
    check("t1_dv", data_valid, 1);
    check("t1_data", data_out, 3'b101);
    check("t1_perr", parity_err, 0);
    check("t1_busy", busy, 0);
    check("t1_odd_perr", parity_err_o1, 1);

    // 2: bad parity (and good under odd sense)
    send(1, 1); send(0, 1); send(0, 1); send(0, 0);
    gap(1);
    check("t2_data", data_out, 3'b111);
    check("t2_perr", parity_err, 1);
    check("t2_odd_perr", parity_err_o1, 0);

    // 3: idle garbage, then a frame with gaps
    send(0, 1); send(0, 1);
    gap(1);
    check("t3_idle_busy", busy, 0);
    send(1, 0);
    gap(3);
    check("t3_gap_busy", busy, 1);
    send(0, 1);
    gap(1);
    send(0, 1); send(0, 0);
    gap(1);
    check("t3_data", data_out, 3'b110);
    check("t3_perr", parity_err, 0);

    // 4: abort by a new start
    send(1, 1); send(0, 1); send(1, 0);
    gap(1);
    check("t4_frame_err", frame_err, 1);
    check("t4_data_held", data_out, 3'b110);
    check("t4_busy", busy, 1);
    send(0, 0); send(0, 1); send(0, 1);
    gap(1);
    check("t4_data", data_out, 3'b100);
    check("t4_perr", parity_err, 0);

    // 5: back-to-back frames
    send(1, 1); send(0, 0); send(0, 1); send(0, 0);
    send(1, 0);
    check("t5_dv1", data_valid, 1);
    check("t5_data1", data_out, 3'b101);
    send(0, 1); send(0, 1); send(0, 0);
    gap(1);
    check("t5_dv2", data_valid, 1);
    check("t5_data2", data_out, 3'b110);

    // 6: asynchronous reset mid-frame
    send(1, 0); send(0, 0);
    @(posedge clk);
    sin_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_data_out", data_out, 0);
    check("t6_dv", data_valid, 0);
    check("t6_perr", parity_err, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_busy", busy, 0);
    #1 reset = 1'b0;
    send(1, 0); send(0, 0); send(0, 1); send(0, 1);
    gap(1);
    check("t6_data", data_out, 3'b100);
    check("t6_perr_after", parity_err, 0);

    // random traffic
    repeat (500) begin
      @(negedge clk);
      sin_valid = ($urandom_range(0, 3) != 0);
      sin_start = ($urandom_range(0, 5) == 0);
      sin_bit   = 1'($urandom_range(0, 1));
    end
    gap(3);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
